mat_soma_ctrl: RTL and testbench

- Sequences the shared 8-bit wrap-around adder (`mod_soma`) to add two square matrices element by element.
- Matrices are 1x1 up to N_MAX x N_MAX, stored row-major in two synchronous read banks (A, B) at a common address.
- Each sum is written to a result bank, one element per cycle.
- Used by the matrix/determinant coprocessor front end as the matrix-addition operation.

---
 rtl/mat_soma_ctrl_if.sv | 34 +++
 rtl/mat_soma_ctrl.sv | 94 +++++++++
 tb/tb_mat_soma_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_soma_ctrl_if.sv
// Bus bundle between the matrix-add sequencer and its banks, adder and requester.
interface mat_soma_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) ();
    logic              start;
    logic [2:0]        tamanho;
    logic              busy;
    logic              done;
    logic              erro;
    logic              overflow;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_a_dado;
    logic [DATA_W-1:0] mem_b_dado;
    logic [DATA_W-1:0] soma_a;
    logic [DATA_W-1:0] soma_b;
    logic [DATA_W-1:0] soma_resultado;
    logic              res_we;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_dado;

    modport master (
        input  start, tamanho, mem_a_dado, mem_b_dado, soma_resultado,
        output busy, done, erro, overflow, mem_rd_en, mem_addr,
               soma_a, soma_b, res_we, res_addr, res_dado
    );

    modport slave (
        output start, tamanho, mem_a_dado, mem_b_dado, soma_resultado,
        input  busy, done, erro, overflow, mem_rd_en, mem_addr,
               soma_a, soma_b, res_we, res_addr, res_dado
    );
endinterface

// File: rtl/mat_soma_ctrl.sv
// Element-wise matrix addition sequencer: streams A/B reads through the shared
// wrap-around adder into the result bank at one element per cycle.
module mat_soma_ctrl #(
    parameter int unsigned N_MAX  = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    mat_soma_ctrl_if.master bus
);
    localparam int unsigned MSB = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, LEITURA, DRENO, FIM} state_t;

    state_t            state;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] tam_sq;
    logic              tam_ok;
    logic              ovf_hit;

    assign tam_ok = (bus.tamanho != 3'd0) && (32'(bus.tamanho) <= N_MAX);
    assign tam_sq = ADDR_W'(bus.tamanho) * ADDR_W'(bus.tamanho);

    // Write stage is combinational on bank data; gated so idle drive stays zero.
    assign bus.soma_a   = bus.res_we ? bus.mem_a_dado : '0;
    assign bus.soma_b   = bus.res_we ? bus.mem_b_dado : '0;
    assign bus.res_dado = bus.res_we ? bus.soma_resultado : '0;

    assign ovf_hit = bus.res_we
                   && (bus.soma_a[MSB] == bus.soma_b[MSB])
                   && (bus.soma_resultado[MSB] != bus.soma_a[MSB]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_addr     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.erro      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.res_we    <= 1'b0;
            bus.res_addr  <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.erro     <= 1'b0;
            // Write stage trails the read stage by exactly one cycle.
            bus.res_we   <= bus.mem_rd_en;
            bus.res_addr <= bus.mem_rd_en ? bus.mem_addr : '0;
            if (ovf_hit) begin
                bus.overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (tam_ok) begin
                            last_addr     <= tam_sq - ADDR_W'(1);
                            bus.overflow  <= 1'b0;
                            bus.busy      <= 1'b1;
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= '0;
                            state         <= LEITURA;
                        end else begin
                            bus.erro <= 1'b1;
                        end
                    end
                end
                LEITURA: begin
                    if (bus.mem_addr == last_addr) begin
                        bus.mem_rd_en <= 1'b0;
                        bus.mem_addr  <= '0;
                        state         <= DRENO;
                    end else begin
                        bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                    end
                end
                DRENO: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= FIM;
                end
                FIM: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat_soma_ctrl.sv
// Directed bench for mat_soma_ctrl with bank, adder and result-bank models.
module tb_mat_soma_ctrl;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   wr_count;

    logic [DATA_W-1:0] mem_a   [32];
    logic [DATA_W-1:0] mem_b   [32];
    logic [DATA_W-1:0] res_mem [32];

    mat_soma_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mat_soma_ctrl #(.N_MAX(5), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.soma_resultado = bus.soma_a + bus.soma_b;

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_a_dado <= mem_a[bus.mem_addr];
            bus.mem_b_dado <= mem_b[bus.mem_addr];
        end
        if (bus.res_we) begin
            res_mem[bus.res_addr] <= bus.res_dado;
            wr_count <= wr_count + 1;
        end
    end

    // Expected {busy,done,rd_en,mem_addr,res_we,res_addr} at cycle c after the accepting edge.
    function automatic logic [13:0] exp_ctl(input int n, input int c);
        int   nn;
        logic rd, we, bsy, dn;
        logic [4:0] ra, wa;
        nn  = n * n;
        rd  = (c >= 1) && (c <= nn);
        ra  = rd ? 5'(c - 1) : 5'd0;
        we  = (c >= 2) && (c <= nn + 1);
        wa  = we ? 5'(c - 2) : 5'd0;
        bsy = (c >= 1) && (c <= nn + 1);
        dn  = (c == nn + 2);
        return {bsy, dn, rd, ra, we, wa};
    endfunction

    function automatic logic [13:0] obs_ctl();
        return {bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.res_we, bus.res_addr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.tamanho = 3'd0;
        bus.mem_a_dado = '0;
        bus.mem_b_dado = '0;
        wr_count = 0;
        step();
        step();
        checks++;
        if ({obs_ctl(), bus.erro, bus.overflow, bus.soma_a, bus.soma_b, bus.res_dado} !== 40'd0) begin
            errors++;
            $display("FAIL reset outputs: got ctl=%h erro=%b ovf=%b sa=%h sb=%h rd=%h, required all zero",
                     obs_ctl(), bus.erro, bus.overflow, bus.soma_a, bus.soma_b, bus.res_dado);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_n2();
        logic [7:0] ea [4] = '{8'h08, 8'h08, 8'hFD, 8'hF5};
        mem_a[0] = 8'd5;  mem_a[1] = 8'd10;  mem_a[2] = 8'hF9; mem_a[3] = 8'hFA;
        mem_b[0] = 8'd3;  mem_b[1] = 8'hFE;  mem_b[2] = 8'd4;  mem_b[3] = 8'hFB;
        step();
        bus.tamanho = 3'd2;
        bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            bus.start = 1'b0;
            checks++;
            if (obs_ctl() !== exp_ctl(2, c)) begin
                errors++;
                $display("FAIL n2 ctl c=%0d: got %h required %h", c, obs_ctl(), exp_ctl(2, c));
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (bus.res_dado !== ea[c-2]) begin
                    errors++;
                    $display("FAIL n2 res_dado c=%0d: got %h required %h", c, bus.res_dado, ea[c-2]);
                end
            end
        end
        checks++;
        if ({res_mem[0], res_mem[1], res_mem[2], res_mem[3], bus.overflow} !== {8'h08, 8'h08, 8'hFD, 8'hF5, 1'b0}) begin
            errors++;
            $display("FAIL n2 bank/ovf: got %h %h %h %h ovf=%b required 08 08 fd f5 ovf=0",
                     res_mem[0], res_mem[1], res_mem[2], res_mem[3], bus.overflow);
        end
    endtask

    task automatic test_overflow_set();
        mem_a[0] = 8'd100;
        mem_b[0] = 8'd100;
        step();
        bus.tamanho = 3'd1;
        bus.start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.start = 1'b0;
            checks++;
            if (obs_ctl() !== exp_ctl(1, c)) begin
                errors++;
                $display("FAIL ovf1 ctl c=%0d: got %h required %h", c, obs_ctl(), exp_ctl(1, c));
            end
            if (c == 2) begin
                checks++;
                if (bus.res_dado !== 8'hC8) begin
                    errors++;
                    $display("FAIL ovf1 res_dado: got %h required c8", bus.res_dado);
                end
            end
        end
        step();
        step();
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf1 sticky after done: got %b required 1", bus.overflow);
        end
    endtask

    task automatic test_erro();
        logic [2:0] bad [2] = '{3'd0, 3'd6};
        for (int i = 0; i < 2; i++) begin
            bus.tamanho = bad[i];
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            checks++;
            if ({bus.erro, bus.busy, bus.mem_rd_en, bus.res_we, bus.overflow} !== 5'b10001) begin
                errors++;
                $display("FAIL erro t=%0d pulse: got erro/busy/rd/we/ovf=%b required 10001",
                         bad[i], {bus.erro, bus.busy, bus.mem_rd_en, bus.res_we, bus.overflow});
            end
            step();
            checks++;
            if ({bus.erro, bus.busy, bus.mem_rd_en, bus.res_we, bus.overflow} !== 5'b00001) begin
                errors++;
                $display("FAIL erro t=%0d after: got erro/busy/rd/we/ovf=%b required 00001",
                         bad[i], {bus.erro, bus.busy, bus.mem_rd_en, bus.res_we, bus.overflow});
            end
        end
    endtask

    task automatic test_overflow_clear();
        mem_a[0] = 8'hFF;
        mem_b[0] = 8'h01;
        step();
        bus.tamanho = 3'd1;
        bus.start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.start = 1'b0;
            checks++;
            if (obs_ctl() !== exp_ctl(1, c) || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL ovf2 c=%0d: got ctl=%h ovf=%b required ctl=%h ovf=0",
                         c, obs_ctl(), bus.overflow, exp_ctl(1, c));
            end
            if (c == 2) begin
                checks++;
                if (bus.res_dado !== 8'h00) begin
                    errors++;
                    $display("FAIL ovf2 res_dado: got %h required 00", bus.res_dado);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int k = 0; k < 25; k++) begin
            mem_a[k] = 8'(k * 11);
            mem_b[k] = 8'(100 + k);
        end
        step();
        wr_count = 0;
        bus.tamanho = 3'd5;
        bus.start = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            step();
            bus.start = (c == 5) || (c >= 27);
            bus.tamanho = (c == 5) ? 3'd2 : (c >= 27 ? 3'd1 : 3'd5);
            checks++;
            if (obs_ctl() !== exp_ctl(5, c)) begin
                errors++;
                $display("FAIL n5 ctl c=%0d: got %h required %h", c, obs_ctl(), exp_ctl(5, c));
            end
            if (c >= 2 && c <= 26) begin
                e = 8'(mem_a[c-2] + mem_b[c-2]);
                checks++;
                if (bus.res_dado !== e) begin
                    errors++;
                    $display("FAIL n5 res_dado c=%0d: got %h required %h", c, bus.res_dado, e);
                end
            end
            if (c == 27) begin
                checks++;
                if (wr_count !== 25) begin
                    errors++;
                    $display("FAIL n5 write count: got %0d required 25", wr_count);
                end
            end
        end
        step();
        bus.start = 1'b0;
        checks++;
        if (obs_ctl() !== exp_ctl(1, 1)) begin
            errors++;
            $display("FAIL n5 restart accept: got %h required %h", obs_ctl(), exp_ctl(1, 1));
        end
        step();
        step();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL n5 restart done: got %b required 1", bus.done);
        end
    endtask

    task automatic test_reset_mid();
        int wc;
        mem_a[0] = 8'd100; mem_b[0] = 8'd100;
        for (int k = 1; k < 9; k++) begin
            mem_a[k] = 8'(k);
            mem_b[k] = 8'(k);
        end
        step();
        bus.tamanho = 3'd3;
        bus.start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            bus.start = 1'b0;
            checks++;
            if (obs_ctl() !== exp_ctl(3, c)) begin
                errors++;
                $display("FAIL rst3 ctl c=%0d: got %h required %h", c, obs_ctl(), exp_ctl(3, c));
            end
        end
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL rst3 ovf before reset: got %b required 1", bus.overflow);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({obs_ctl(), bus.erro, bus.overflow, bus.soma_a, bus.soma_b, bus.res_dado} !== 40'd0) begin
            errors++;
            $display("FAIL rst3 outputs: got ctl=%h ovf=%b sa=%h sb=%h rd=%h required all zero",
                     obs_ctl(), bus.overflow, bus.soma_a, bus.soma_b, bus.res_dado);
        end
        wc = wr_count;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (wr_count !== wc || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst3 quiet: got writes=%0d busy=%b required writes=%0d busy=0", wr_count, bus.busy, wc);
        end
        mem_a[0] = 8'd1;
        mem_b[0] = 8'd2;
        bus.tamanho = 3'd1;
        bus.start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.start = 1'b0;
            checks++;
            if (obs_ctl() !== exp_ctl(1, c) || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL rst3 rerun c=%0d: got ctl=%h ovf=%b required ctl=%h ovf=0",
                         c, obs_ctl(), bus.overflow, exp_ctl(1, c));
            end
            if (c == 2) begin
                checks++;
                if (bus.res_dado !== 8'h03) begin
                    errors++;
                    $display("FAIL rst3 rerun res_dado: got %h required 03", bus.res_dado);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_n2();
        test_overflow_set();
        test_erro();
        test_overflow_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
